// File: rtl/vector_angle_est.sv
`default_nettype none
// ============================================================================
//  Module      : vector_angle_est
//  Description : Vectoring-mode iterative CORDIC. Converts a signed 8-bit
//                (X, Y) point to an 8-bit polar angle plus its magnitude.
//  Revision    : 1.0 - initial release
// ============================================================================
module vector_angle_est #(
    parameter int ITER = 8
) (
    input  logic       ACLK,
    input  logic       ARESETN,
    input  logic       ENB,
    input  logic [7:0] Xcoord,
    input  logic [7:0] Ycoord,
    output logic       BUSY,
    output logic [7:0] Angle,
    output logic [7:0] Magnitude,
    output logic       VALID
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ROT   = 2'd1,
        S_SCALE = 2'd2
    } state_t;

    localparam logic [3:0]  c_last_iter = 4'(ITER - 1);
    localparam logic [11:0] c_z_pi      = 12'd2048;

    state_t              r_state;
    state_t              w_next;
    logic                w_busy;

    logic signed [11:0]  r_x;
    logic signed [11:0]  r_y;
    logic        [11:0]  r_z;
    logic        [3:0]   r_i;
    logic                r_zero;
    logic        [7:0]   r_angle;
    logic        [7:0]   r_mag;
    logic                r_valid;

    logic signed [11:0]  w_xin;
    logic signed [11:0]  w_yin;
    logic signed [11:0]  w_x0;
    logic signed [11:0]  w_y0;
    logic        [11:0]  w_z0;
    logic signed [11:0]  w_xsh;
    logic signed [11:0]  w_ysh;
    logic signed [11:0]  w_xn;
    logic signed [11:0]  w_yn;
    logic        [11:0]  w_zn;
    logic        [11:0]  w_t;
    logic signed [13:0]  w_xe;
    logic signed [13:0]  w_m;
    logic signed [13:0]  w_mr;
    logic        [7:0]   w_mag;
    logic        [7:0]   w_ang;

    // Sign-extend and append two guard fraction bits.
    assign w_xin = {{2{Xcoord[7]}}, Xcoord, 2'b00};
    assign w_yin = {{2{Ycoord[7]}}, Ycoord, 2'b00};

    // Fold left half-plane onto the right; -128 still fits as +512 here.
    always_comb begin
        w_x0 = w_xin;
        w_y0 = w_yin;
        w_z0 = 12'd0;
        if (Xcoord[7]) begin
            w_x0 = -w_xin;
            w_y0 = -w_yin;
            w_z0 = c_z_pi;
        end
    end

    // atan(2^-i) in pi/2048 units.
    always_comb begin
        w_t = 12'd0;
        case (r_i)
            4'd0:    w_t = 12'd512;
            4'd1:    w_t = 12'd302;
            4'd2:    w_t = 12'd160;
            4'd3:    w_t = 12'd81;
            4'd4:    w_t = 12'd41;
            4'd5:    w_t = 12'd20;
            4'd6:    w_t = 12'd10;
            4'd7:    w_t = 12'd5;
            4'd8:    w_t = 12'd3;
            4'd9:    w_t = 12'd1;
            default: w_t = 12'd0;
        endcase
    end

    assign w_xsh = r_x >>> r_i;
    assign w_ysh = r_y >>> r_i;

    // Drive y towards zero, accumulating the rotation applied into z.
    always_comb begin
        w_xn = r_x + w_ysh;
        w_yn = r_y - w_xsh;
        w_zn = r_z + w_t;
        if (r_y[11]) begin
            w_xn = r_x - w_ysh;
            w_yn = r_y + w_xsh;
            w_zn = r_z - w_t;
        end
    end

    // Remove the CORDIC gain (~1/1.6468), then drop the guard bits with rounding.
    assign w_xe = {{2{r_x[11]}}, r_x};
    assign w_m  = (w_xe >>> 1) + (w_xe >>> 3) - (w_xe >>> 6) - (w_xe >>> 9);
    assign w_mr = (w_m + 14'sd2) >>> 2;

    always_comb begin
        w_mag = w_mr[7:0];
        if (w_mr[13]) begin
            w_mag = 8'h00;
        end else if (w_mr > 14'sd255) begin
            w_mag = 8'hFF;
        end
    end

    // Round z to 8 bits; the wrap at 2*pi is intentional.
    assign w_ang = 8'(({1'b0, r_z} + 13'd8) >> 4);

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        w_busy = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (ENB) begin
                    w_next = S_ROT;
                end
            end
            S_ROT: begin
                w_busy = 1'b1;
                if (r_i == c_last_iter) begin
                    w_next = S_SCALE;
                end
            end
            S_SCALE: begin
                w_busy = 1'b1;
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_x     <= 12'sd0;
            r_y     <= 12'sd0;
            r_z     <= 12'd0;
            r_i     <= 4'd0;
            r_zero  <= 1'b0;
            r_angle <= 8'h00;
            r_mag   <= 8'h00;
            r_valid <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (ENB) begin
                        r_x    <= w_x0;
                        r_y    <= w_y0;
                        r_z    <= w_z0;
                        r_i    <= 4'd0;
                        r_zero <= (Xcoord == 8'h00) && (Ycoord == 8'h00);
                    end
                end
                S_ROT: begin
                    r_x <= w_xn;
                    r_y <= w_yn;
                    r_z <= w_zn;
                    r_i <= r_i + 4'd1;
                end
                S_SCALE: begin
                    r_angle <= r_zero ? 8'h00 : w_ang;
                    r_mag   <= r_zero ? 8'h00 : w_mag;
                    r_valid <= 1'b1;
                end
                default: begin
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

    assign BUSY      = w_busy;
    assign Angle     = r_angle;
    assign Magnitude = r_mag;
    assign VALID     = r_valid;

endmodule
`default_nettype wire

// File: tb/tb_vector_angle_est.sv
`default_nettype none
// ============================================================================
//  Module      : tb_vector_angle_est
//  Description : Self-checking bench for vector_angle_est.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_vector_angle_est;

    localparam int ITER = 8;
    localparam int LAT  = ITER + 2;
    localparam real PI  = 3.14159265358979;

    logic       ACLK    = 1'b0;
    logic       ARESETN = 1'b0;
    logic       ENB     = 1'b0;
    logic [7:0] Xcoord  = 8'h00;
    logic [7:0] Ycoord  = 8'h00;
    logic       BUSY;
    logic [7:0] Angle;
    logic [7:0] Magnitude;
    logic       VALID;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    vector_angle_est #(.ITER(ITER)) dut (
        .ACLK      (ACLK),
        .ARESETN   (ARESETN),
        .ENB       (ENB),
        .Xcoord    (Xcoord),
        .Ycoord    (Ycoord),
        .BUSY      (BUSY),
        .Angle     (Angle),
        .Magnitude (Magnitude),
        .VALID     (VALID)
    );

    always #5 ACLK = ~ACLK;
    always @(posedge ACLK) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input int obs, input int exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Tolerance check; angles compare on the 256-step circle.
    task automatic chk_near(input string tag, input int obs, input int exp,
                            input int tol, input bit wrap);
        int d;
        d = obs - exp;
        if (wrap) begin
            d = d & 255;
            if (d > 127) d = d - 256;
        end
        n_vec++;
        assert ((d >= -tol && d <= tol) === 1'b1) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d (+/-%0d)", tag, obs, exp, tol);
        end
    endtask

    // Reference: the vectoring algorithm in unbounded integer arithmetic.
    function automatic void ref_model(input int xi, input int yi,
                                      output int ang, output int mag);
        int t [10] = '{512, 302, 160, 81, 41, 20, 10, 5, 3, 1};
        int x, y, z, xn, m;
        if (xi == 0 && yi == 0) begin
            ang = 0;
            mag = 0;
            return;
        end
        x = xi * 4;
        y = yi * 4;
        z = 0;
        if (xi < 0) begin
            x = -x;
            y = -y;
            z = 2048;
        end
        for (int i = 0; i < ITER; i++) begin
            if (y >= 0) begin
                xn = x + (y >>> i);
                y  = y - (x >>> i);
                z  = z + t[i];
            end else begin
                xn = x - (y >>> i);
                y  = y + (x >>> i);
                z  = z - t[i];
            end
            x = xn;
        end
        ang = ((z + 8) >>> 4) & 255;
        m   = (x >>> 1) + (x >>> 3) - (x >>> 6) - (x >>> 9);
        mag = (m + 2) >>> 2;
        if (mag < 0)   mag = 0;
        if (mag > 255) mag = 255;
    endfunction

    task automatic convert(input int xi, input int yi,
                           output int ang, output int mag, output int lat);
        @(negedge ACLK);
        Xcoord = 8'(xi);
        Ycoord = 8'(yi);
        ENB    = 1'b1;
        @(negedge ACLK);
        ENB = 1'b0;
        lat = 1;
        while (VALID !== 1'b1 && lat < 40) begin
            @(negedge ACLK);
            lat++;
        end
        ang = int'(Angle);
        mag = int'(Magnitude);
    endtask

    task automatic run_check(input int xi, input int yi, input string tag,
                             output int ang, output int mag);
        int ea, em, lat;
        convert(xi, yi, ang, mag, lat);
        ref_model(xi, yi, ea, em);
        chk({tag, " angle"}, ang, ea);
        chk({tag, " mag"}, mag, em);
        chk({tag, " latency"}, lat, LAT);
    endtask

    task automatic spec_check(input int xi, input int yi, input int sa,
                              input int sm, input string tag);
        int a, m;
        run_check(xi, yi, tag, a, m);
        chk_near({tag, " angle~"}, a, sa, 1, 1'b1);
        chk_near({tag, " mag~"}, m, sm, 1, 1'b0);
    endtask

    initial begin
        int a, m, ea, em, lat, c0, pulses;
        int stamps[$];
        real th, xr, yr;

        // Reset state
        repeat (3) @(negedge ACLK);
        chk("reset busy", int'(BUSY), 0);
        chk("reset valid", int'(VALID), 0);
        chk("reset angle", int'(Angle), 0);
        chk("reset mag", int'(Magnitude), 0);
        ARESETN = 1'b1;

        // Make outputs non-zero, then abort a conversion mid-ROT
        spec_check(64, -64, 8'hE0, 91, "diag 64,-64");
        @(negedge ACLK);
        Xcoord = 8'(100); Ycoord = 8'(50); ENB = 1'b1;
        @(negedge ACLK);
        ENB = 1'b0;
        repeat (3) @(negedge ACLK);
        chk("midrot busy", int'(BUSY), 1);
        ARESETN = 1'b0;
        #1;
        chk("abort busy", int'(BUSY), 0);
        chk("abort angle", int'(Angle), 0);
        chk("abort mag", int'(Magnitude), 0);
        pulses = 0;
        repeat (2) begin @(negedge ACLK); if (VALID) pulses++; end
        ARESETN = 1'b1;
        repeat (LAT + 4) begin @(negedge ACLK); if (VALID) pulses++; end
        chk("abort no valid", pulses, 0);

        // First conversion after reset, axes, diagonals, boundaries
        spec_check(32, 0, 8'h00, 32, "pos x");
        @(negedge ACLK);
        chk("valid one cycle", int'(VALID), 0);
        spec_check(0, 32, 8'h40, 32, "pos y");
        spec_check(-32, 0, 8'h80, 32, "neg x");
        spec_check(0, -32, 8'hC0, 32, "neg y");
        spec_check(32, 32, 8'h20, 45, "diag 32,32");
        spec_check(-128, -128, 8'hA0, 181, "diag -128,-128");
        spec_check(0, 0, 8'h00, 0, "zero");
        spec_check(-128, 0, 8'h80, 128, "x -128");
        spec_check(127, -1, 8'h00, 127, "wrap 127,-1");

        // ENB held high: three back-to-back conversions
        @(negedge ACLK);
        Xcoord = 8'(40); Ycoord = 8'(-70); ENB = 1'b1;
        c0 = cyc;
        for (int k = 0; k < 4 * LAT && stamps.size() < 3; k++) begin
            @(negedge ACLK);
            if (VALID) begin
                stamps.push_back(cyc);
                if (stamps.size() == 1) begin
                    ref_model(40, -70, ea, em);
                    chk("b2b angle", int'(Angle), ea);
                    chk("b2b mag", int'(Magnitude), em);
                end
            end
        end
        ENB = 1'b0;
        chk("b2b pulse count", stamps.size(), 3);
        if (stamps.size() == 3) begin
            chk("b2b first latency", stamps[0] - c0, LAT);
            chk("b2b interval 1", stamps[1] - stamps[0], LAT);
            chk("b2b interval 2", stamps[2] - stamps[1], LAT);
        end
        pulses = 0;
        repeat (LAT + 2) begin @(negedge ACLK); if (VALID) pulses++; end
        chk("b2b stops", pulses, 0);

        // ENB pulse during BUSY is dropped
        @(negedge ACLK);
        Xcoord = 8'(20); Ycoord = 8'(90); ENB = 1'b1;
        @(negedge ACLK);
        ENB = 1'b0;
        repeat (3) @(negedge ACLK);
        Xcoord = 8'(-50); Ycoord = 8'(10); ENB = 1'b1;
        @(negedge ACLK);
        ENB = 1'b0;
        pulses = 0;
        a = -1; m = -1;
        repeat (3 * LAT) begin
            @(negedge ACLK);
            if (VALID) begin
                pulses++;
                if (pulses == 1) begin a = int'(Angle); m = int'(Magnitude); end
            end
        end
        ref_model(20, 90, ea, em);
        chk("drop pulses", pulses, 1);
        chk("drop angle", a, ea);
        chk("drop mag", m, em);

        // Input change during ROT does not affect the result
        @(negedge ACLK);
        Xcoord = 8'(-70); Ycoord = 8'(-30); ENB = 1'b1;
        @(negedge ACLK);
        ENB = 1'b0; Xcoord = 8'(5); Ycoord = 8'(5);
        lat = 1;
        while (VALID !== 1'b1 && lat < 40) begin @(negedge ACLK); lat++; end
        ref_model(-70, -30, ea, em);
        chk("hold latency", lat, LAT);
        chk("hold angle", int'(Angle), ea);
        chk("hold mag", int'(Magnitude), em);

        // Randomized points
        for (int k = 0; k < 40; k++) begin
            int xi, yi;
            xi = int'($urandom_range(255, 0)) - 128;
            yi = int'($urandom_range(255, 0)) - 128;
            run_check(xi, yi, $sformatf("rnd %0d,%0d", xi, yi), a, m);
        end

        // Closed loop: ideal rotation by -Angle lands near the X axis
        convert(32, 16, a, m, lat);
        th = -real'(a) * PI / 128.0;
        xr = 32.0 * $cos(th) - 16.0 * $sin(th);
        yr = 32.0 * $sin(th) + 16.0 * $cos(th);
        chk_near("loop y", $rtoi(yr + (yr < 0.0 ? -0.5 : 0.5)), 0, 2, 1'b0);
        chk_near("loop x", $rtoi(xr + 0.5), m, 2, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
